// File: rtl/axis_i2c_cfg_framer.sv
// Frames 16-bit config words into 3-byte I2C write frames (dev addr+W, reg, data).
// Optional CFG_DELAY_CMD_EN: words with reg 8'hFF become inter-write delay commands.
module axis_i2c_cfg_framer #(
  parameter logic [6:0] DEV_ADDR   = 7'h21,
  parameter int         NUM_WORDS  = 24,
  parameter int         DELAY_UNIT = 1000,
  localparam int        CW         = $clog2(NUM_WORDS + 1)
) (
  input  logic          clk_i,
  input  logic          arst_i,
  input  logic          restart_i,
  input  logic [15:0]   s_axis_tdata,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  output logic [7:0]    m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          m_axis_tlast,
  output logic [CW-1:0] word_cnt_o,
  output logic          done_o,
  output logic          busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    DEV,
    REG,
    DAT
`ifdef CFG_DELAY_CMD_EN
    , DELAY
`endif
  } state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_WORDS);

  state_t        state;
  logic [15:0]   word_q;
  logic          word_done;
  logic          at_max;
  logic          hit_last;
  logic [CW-1:0] cnt_inc;

`ifdef CFG_DELAY_CMD_EN
  localparam int DW = $clog2(255 * DELAY_UNIT + 1);
  logic [DW-1:0] dly_cnt;
`endif

  assign busy_o   = (state != IDLE);
  assign cnt_inc  = word_cnt_o + CW'(1);
  assign at_max   = (word_cnt_o == LAST_CNT);
  assign hit_last = ~at_max & (cnt_inc == LAST_CNT);

  // A word completes either on the final byte handshake or when a delay expires.
  always_comb begin
    word_done = (state == DAT) && m_axis_tvalid && m_axis_tready;
`ifdef CFG_DELAY_CMD_EN
    if ((state == DELAY) && (dly_cnt <= DW'(1))) word_done = 1'b1;
`endif
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state         <= IDLE;
      word_q        <= '0;
      s_axis_tready <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      word_cnt_o    <= '0;
      done_o        <= 1'b0;
`ifdef CFG_DELAY_CMD_EN
      dly_cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (restart_i) begin
            word_cnt_o <= '0;
            done_o     <= 1'b0;
          end
          if (s_axis_tvalid && s_axis_tready) begin
            word_q        <= s_axis_tdata;
            s_axis_tready <= 1'b0;
`ifdef CFG_DELAY_CMD_EN
            if (s_axis_tdata[15:8] == 8'hFF) begin
              state   <= DELAY;
              dly_cnt <= DW'(s_axis_tdata[7:0]) * DW'(DELAY_UNIT);
            end else
`endif
            begin
              state         <= DEV;
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= {DEV_ADDR, 1'b0};
              m_axis_tlast  <= 1'b0;
            end
          end else begin
            // tready stays registered so it never depends on the downstream tready.
            s_axis_tready <= restart_i | ~done_o;
          end
        end
        DEV: begin
          if (m_axis_tvalid && m_axis_tready) begin
            state        <= REG;
            m_axis_tdata <= word_q[15:8];
          end
        end
        REG: begin
          if (m_axis_tvalid && m_axis_tready) begin
            state        <= DAT;
            m_axis_tdata <= word_q[7:0];
            m_axis_tlast <= 1'b1;
          end
        end
        DAT: ;
`ifdef CFG_DELAY_CMD_EN
        DELAY: begin
          if (dly_cnt > DW'(1)) dly_cnt <= dly_cnt - DW'(1);
        end
`endif
        default: state <= IDLE;
      endcase

      // Shared completion path; the count saturates at NUM_WORDS.
      if (word_done) begin
        state         <= IDLE;
        m_axis_tvalid <= 1'b0;
        m_axis_tdata  <= '0;
        m_axis_tlast  <= 1'b0;
        if (!at_max) word_cnt_o <= cnt_inc;
        if (hit_last) done_o <= 1'b1;
        s_axis_tready <= ~(done_o | hit_last);
      end
    end
  end

endmodule

// File: tb/tb_axis_i2c_cfg_framer.sv
// Table-driven bench for axis_i2c_cfg_framer plus hand-written reset/done/restart/delay sequences.
module tb_axis_i2c_cfg_framer;

  localparam int NUM_WORDS = 24;
  localparam int CW        = $clog2(NUM_WORDS + 1);

  logic          clk_i = 1'b0;
  logic          arst_i;
  logic          restart_i;
  logic [15:0]   s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [7:0]    m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [CW-1:0] word_cnt_o;
  logic          done_o;
  logic          busy_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] word;
    int          stall;
    logic [23:0] expBytes;
  } vec_t;

  vec_t vecs[$];

  always #5 clk_i = ~clk_i;

  axis_i2c_cfg_framer #(
    .DEV_ADDR   (7'h21),
    .NUM_WORDS  (NUM_WORDS),
    .DELAY_UNIT (10)
  ) dut (
    .clk_i         (clk_i),
    .arst_i        (arst_i),
    .restart_i     (restart_i),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .word_cnt_o    (word_cnt_o),
    .done_o        (done_o),
    .busy_o        (busy_o)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Offers one word, collects its frame, optionally stalling the REG byte; returns at the negedge after DAT.
  task automatic applyStimulus(input logic [15:0] word, input int stall,
                               output logic [23:0] bytes, output logic [2:0] lasts, output int cycles);
    int n;
    int got;
    int stallLeft;
    bytes = '0;
    lasts = '0;
    got = 0;
    cycles = 0;
    stallLeft = stall;
    s_axis_tdata  = word;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    n = 0;
    while (!s_axis_tready && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("accept_timeout", 32'(n < 50), 1);
    @(negedge clk_i);
    s_axis_tvalid = 1'b0;
    checkOutput("first_valid_latency", m_axis_tvalid, 1);
    while (got < 3 && cycles < 100) begin
      if (got == 1 && stallLeft > 0) begin
        m_axis_tready = 1'b0;
        stallLeft--;
        checkOutput("stall_hold_data", {m_axis_tvalid, m_axis_tdata}, {1'b1, word[15:8]});
        checkOutput("stall_s_tready", s_axis_tready, 0);
      end else begin
        m_axis_tready = 1'b1;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        bytes = {bytes[15:0], m_axis_tdata};
        lasts = {lasts[1:0], m_axis_tlast};
        got++;
      end
      @(negedge clk_i);
      cycles++;
    end
    m_axis_tready = 1'b1;
    checkOutput("frame_timeout", got, 3);
    checkOutput("valid_drop", m_axis_tvalid, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [23:0] bytes;
    logic [2:0]  lasts;
    int          cycles;
    int          expCnt;
    int          tlastTotal;
    int          byteTotal;
    logic        anyReady;
    logic        anyValid;
    logic [15:0] w;
`ifdef CFG_DELAY_CMD_EN
    int          busyCycles;
    logic        sawValid;
`endif

    vecs.push_back('{16'h1234, 0, 24'h421234});
    vecs.push_back('{16'h1234, 5, 24'h421234});
    vecs.push_back('{16'hA55A, 0, 24'h42A55A});
    vecs.push_back('{16'h00FF, 2, 24'h4200FF});
    vecs.push_back('{16'h7E81, 1, 24'h427E81});
`ifndef CFG_DELAY_CMD_EN
    vecs.push_back('{16'hFF03, 0, 24'h42FF03});
`endif

    arst_i        = 1'b1;
    restart_i     = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b0;
    repeat (3) @(negedge clk_i);
    checkOutput("reset_m_tvalid", m_axis_tvalid, 0);
    checkOutput("reset_m_tdata", m_axis_tdata, 0);
    checkOutput("reset_m_tlast", m_axis_tlast, 0);
    checkOutput("reset_word_cnt", word_cnt_o, 0);
    checkOutput("reset_done", done_o, 0);
    checkOutput("reset_busy", busy_o, 0);
    checkOutput("reset_s_tready", s_axis_tready, 0);
    arst_i = 1'b0;
    #1;
    checkOutput("s_tready_at_release", s_axis_tready, 0);
    @(negedge clk_i);
    checkOutput("s_tready_after_release", s_axis_tready, 1);

    expCnt = 0;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].word, vecs[i].stall, bytes, lasts, cycles);
      expCnt++;
      checkOutput("frame_bytes", bytes, vecs[i].expBytes);
      checkOutput("frame_tlast", lasts, 3'b001);
      checkOutput("frame_cycles", cycles, 3 + vecs[i].stall);
      checkOutput("word_cnt", word_cnt_o, expCnt);
      checkOutput("busy_idle", busy_o, 0);
    end

`ifdef CFG_DELAY_CMD_EN
    s_axis_tdata  = 16'hFF03;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    checkOutput("delay_ready", s_axis_tready, 1);
    @(negedge clk_i);
    s_axis_tvalid = 1'b0;
    busyCycles = 0;
    sawValid   = 1'b0;
    while (busy_o && busyCycles < 200) begin
      if (m_axis_tvalid) sawValid = 1'b1;
      @(negedge clk_i);
      busyCycles++;
    end
    expCnt++;
    checkOutput("delay_cycles", busyCycles, 30);
    checkOutput("delay_no_bytes", sawValid, 0);
    checkOutput("delay_word_cnt", word_cnt_o, expCnt);
    applyStimulus(16'h0102, 0, bytes, lasts, cycles);
    expCnt++;
    checkOutput("post_delay_bytes", bytes, 24'h420102);
    checkOutput("post_delay_word_cnt", word_cnt_o, expCnt);
`endif

    // Async reset while the REG byte is on the bus.
    s_axis_tdata  = 16'h5678;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    @(negedge clk_i);
    s_axis_tvalid = 1'b0;
    @(negedge clk_i);
    checkOutput("pre_reset_reg_byte", m_axis_tdata, 8'h56);
    m_axis_tready = 1'b0;
    arst_i = 1'b1;
    #1;
    checkOutput("midreset_m_tvalid", m_axis_tvalid, 0);
    checkOutput("midreset_word_cnt", word_cnt_o, 0);
    checkOutput("midreset_busy", busy_o, 0);
    @(negedge clk_i);
    arst_i = 1'b0;
    @(negedge clk_i);
    applyStimulus(16'h9ABC, 0, bytes, lasts, cycles);
    checkOutput("post_reset_bytes", bytes, 24'h429ABC);
    checkOutput("post_reset_word_cnt", word_cnt_o, 1);

    restart_i = 1'b1;
    @(negedge clk_i);
    restart_i = 1'b0;
    checkOutput("restart_clear_cnt", word_cnt_o, 0);

    tlastTotal = 0;
    byteTotal  = 0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      w = {8'(8'h10 + i), 8'(3 * i)};
      applyStimulus(w, 0, bytes, lasts, cycles);
      if (bytes == {8'h42, w}) byteTotal += 3;
      tlastTotal += int'(lasts[0]) + int'(lasts[1]) + int'(lasts[2]);
      checkOutput("run_done", done_o, 32'(i == NUM_WORDS - 1));
    end
    checkOutput("run_bytes", byteTotal, 72);
    checkOutput("run_tlast", tlastTotal, 24);
    checkOutput("run_word_cnt", word_cnt_o, NUM_WORDS);

    s_axis_tdata  = 16'hBEEF;
    s_axis_tvalid = 1'b1;
    anyReady = 1'b0;
    anyValid = 1'b0;
    repeat (10) begin
      @(negedge clk_i);
      anyReady |= s_axis_tready;
      anyValid |= m_axis_tvalid;
    end
    checkOutput("done_s_tready", anyReady, 0);
    checkOutput("done_no_output", anyValid, 0);
    checkOutput("done_cnt_hold", word_cnt_o, NUM_WORDS);
    checkOutput("done_sticky", done_o, 1);

    restart_i = 1'b1;
    @(negedge clk_i);
    restart_i = 1'b0;
    checkOutput("restart_cnt", word_cnt_o, 0);
    checkOutput("restart_done", done_o, 0);
    applyStimulus(16'hBEEF, 0, bytes, lasts, cycles);
    checkOutput("restart_bytes", bytes, 24'h42BEEF);
    checkOutput("restart_word_cnt", word_cnt_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
